udp_decode: RTL and testbench
=============================

UDP_DECODE -- requirements
Module: udp_decode

Interface
REQ-001 Parameter LOCAL_PORT, default 16'd1234, is the UDP destination port accepted by this block.
REQ-002 Parameter CSUM_EN, default 1, enables UDP checksum verification; 0 skips it.
REQ-003 clk  in  1  clock; all logic is on the rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 valid  in  1  frame active; din carries one byte per cycle while high; falling edge ends the frame.
REQ-006 din  in  8  frame byte stream.
REQ-007 hdr_done  in  1  one-cycle pulse from the IPv4 stage marking the end of the IPv4 header.
REQ-008 ip_sa  in  32  IPv4 source address, stable from hdr_done until frame end.
REQ-009 ip_da  in  32  IPv4 destination address, stable from hdr_done until frame end.
REQ-010 src_port  out  16  UDP source port, registered.
REQ-011 dst_port  out  16  UDP destination port, registered.
REQ-012 udp_len  out  16  UDP length field, registered.
REQ-013 pl_data  out  8  payload byte.
REQ-014 pl_valid  out  1  pl_data is a payload byte this cycle.
REQ-015 pl_last  out  1  the current pl_data is the final payload byte.
REQ-016 done  out  1  datagram accepted, sticky.
REQ-017 err  out  1  datagram malformed, truncated or failed checksum, sticky.

Function
REQ-018 States are IDLE, HDR, PAYLOAD, CHECK and DROP; hdr_done in any state loads HDR, clears done and err, zeroes the byte counter and seeds the checksum.
REQ-019 The first UDP header byte is din on the first cycle after hdr_done on which valid is high.
REQ-020 HDR captures 8 bytes, big-endian, on valid cycles: src_port is bytes 0-1, dst_port bytes 2-3, udp_len bytes 4-5 and the checksum field bytes 6-7.
REQ-021 At the end of byte 7: if udp_len < 8, set err and go to DROP.
REQ-022 At the end of byte 7: else if dst_port != LOCAL_PORT, go to DROP with neither err nor done set.
REQ-023 At the end of byte 7: else if udp_len == 8, go to CHECK.
REQ-024 At the end of byte 7: otherwise, go to PAYLOAD.
REQ-025 PAYLOAD forwards each valid din byte with one cycle of latency: pl_data = din, pl_valid = 1.
REQ-026 PAYLOAD forwards exactly udp_len-8 bytes.
REQ-027 pl_last is asserted with byte udp_len-9, after which the state goes to CHECK.
REQ-028 Bytes after udp_len (Ethernet padding) are ignored.
REQ-029 A valid-low cycle in IDLE or DROP leaves the block in IDLE.
REQ-030 valid going low in HDR or PAYLOAD before the byte count completes sets err, emits no pl_last, and returns to IDLE.
REQ-031 Checksum: 16-bit one's-complement sum with end-around carry.
REQ-032 The checksum seed is ip_sa[31:16] + ip_sa[15:0] + ip_da[31:16] + ip_da[15:0] + 16'h0011, with udp_len added once it is captured.
REQ-033 The checksum then accumulates every header word, checksum field included, and every payload word.
REQ-034 An odd final payload byte is padded in the low byte with 8'h00.
REQ-035 CHECK lasts one cycle: if CSUM_EN and the checksum field != 0 and the sum != 16'hFFFF, set err; otherwise set done.
REQ-036 CHECK then goes to IDLE.
REQ-037 done and err are never both 1, and each holds until the next hdr_done or rst.
REQ-038 Payload bytes are forwarded before the checksum verdict; the consumer discards the datagram on err.
REQ-039 The byte counter is 16 bits and saturates, never wrapping.
REQ-040 hdr_done arriving mid-datagram aborts the current datagram silently, without setting err, and restarts HDR.

Reset
REQ-041 While rst is high, the state is IDLE and the counter, checksum, src_port, dst_port, udp_len, pl_data, pl_valid, pl_last, done and err are all 0.
REQ-042 rst mid-datagram discards it with no pl_last, done or err, and takes precedence over hdr_done in the same cycle.

Verification
REQ-043 Scenario: ip_sa=C0A80102, ip_da=C0A80101, header 1F90 04D2 000A 0000, payload AB CD -> src_port=1F90, dst_port=04D2, udp_len=000A, pl_data AB then CD with pl_last on CD, done=1 and err=0 one cycle after the CD input.
REQ-044 Scenario: same datagram with the checksum field set to the correct value -> done=1; the correct value XOR 0x0001 -> err=1 and done=0, with both payload bytes still forwarded.
REQ-045 Scenario: dst_port=0050 -> no pl_valid, done=0, err=0, and dst_port reads 0050.
REQ-046 Scenario: udp_len=0005 -> err=1 after byte 7 and no pl_valid; udp_len=0008 -> done=1 and no pl_valid.
REQ-047 Scenario: udp_len=000C with valid dropped after 2 payload bytes -> err=1 and no pl_last.
REQ-048 Scenario: rst pulsed during the payload -> all outputs are 0 next cycle; a following hdr_done plus a good datagram -> done=1.

Source files
------------

// File: rtl/udp_decode.sv
// UDP header decoder: captures the 8-byte UDP header that follows the IPv4 header,
// forwards the payload with one cycle of latency and verifies the UDP checksum.
module udp_decode #(
    parameter logic [15:0] LOCAL_PORT = 16'd1234,
    parameter bit          CSUM_EN    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [7:0]  din_i,
    input  logic        hdr_done_i,
    input  logic [31:0] ip_sa_i,
    input  logic [31:0] ip_da_i,
    output logic [15:0] src_port_o,
    output logic [15:0] dst_port_o,
    output logic [15:0] udp_len_o,
    output logic [7:0]  pl_data_o,
    output logic        pl_valid_o,
    output logic        pl_last_o,
    output logic        done_o,
    output logic        err_o
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned WORD_W = 16;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR     = 3'd1,
        PAYLOAD = 3'd2,
        CHECK   = 3'd3,
        DROP    = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WORD_W-1:0]   sum_q, sum_d;
    logic [BYTE_W-1:0]   hi_q, hi_d;
    logic [WORD_W-1:0]   src_port_q, src_port_d;
    logic [WORD_W-1:0]   dst_port_q, dst_port_d;
    logic [WORD_W-1:0]   udp_len_q, udp_len_d;
    logic [WORD_W-1:0]   csum_q, csum_d;
    logic [BYTE_W-1:0]   pl_data_q, pl_data_d;
    logic                pl_valid_q, pl_valid_d;
    logic                pl_last_q, pl_last_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                valid_q;

    logic [CNT_W-1:0]    cnt_inc_c;
    logic [WORD_W-1:0]   word_c;
    logic [WORD_W-1:0]   seed_c;

    // One's-complement 16-bit add with end-around carry.
    function automatic logic [WORD_W-1:0] oc_add(input logic [WORD_W-1:0] a,
                                                 input logic [WORD_W-1:0] b);
        logic [WORD_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[WORD_W-1:0] + WORD_W'(s[WORD_W]);
    endfunction

    assign cnt_inc_c = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    assign word_c    = {hi_q, din_i};
    // Pseudo-header without udp_len, which joins once it has been captured.
    assign seed_c    = oc_add(oc_add(oc_add(oc_add(ip_sa_i[31:16], ip_sa_i[15:0]),
                                             ip_da_i[31:16]), ip_da_i[15:0]),
                              WORD_W'(16'h0011));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sum_q      <= '0;
            hi_q       <= '0;
            src_port_q <= '0;
            dst_port_q <= '0;
            udp_len_q  <= '0;
            csum_q     <= '0;
            pl_data_q  <= '0;
            pl_valid_q <= 1'b0;
            pl_last_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sum_q      <= sum_d;
            hi_q       <= hi_d;
            src_port_q <= src_port_d;
            dst_port_q <= dst_port_d;
            udp_len_q  <= udp_len_d;
            csum_q     <= csum_d;
            pl_data_q  <= pl_data_d;
            pl_valid_q <= pl_valid_d;
            pl_last_q  <= pl_last_d;
            done_q     <= done_d;
            err_q      <= err_d;
            valid_q    <= valid_i;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sum_d      = sum_q;
        hi_d       = hi_q;
        src_port_d = src_port_q;
        dst_port_d = dst_port_q;
        udp_len_d  = udp_len_q;
        csum_d     = csum_q;
        pl_data_d  = pl_data_q;
        pl_valid_d = 1'b0;
        pl_last_d  = 1'b0;
        done_d     = done_q;
        err_d      = err_q;

        if (hdr_done_i) begin
            // A new header always wins, silently abandoning any datagram in flight.
            state_d = HDR;
            cnt_d   = '0;
            sum_d   = seed_c;
            done_d  = 1'b0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                HDR: begin
                    if (valid_i) begin
                        cnt_d = cnt_inc_c;
                        if (!cnt_q[0]) hi_d = din_i;
                        else           sum_d = oc_add(sum_q, word_c);
                        case (cnt_q[2:0])
                            3'd0: src_port_d[15:8] = din_i;
                            3'd1: src_port_d[7:0]  = din_i;
                            3'd2: dst_port_d[15:8] = din_i;
                            3'd3: dst_port_d[7:0]  = din_i;
                            3'd4: udp_len_d[15:8]  = din_i;
                            3'd5: begin
                                // Length enters the sum twice: header word and pseudo-header.
                                udp_len_d[7:0] = din_i;
                                sum_d          = oc_add(oc_add(sum_q, word_c), word_c);
                            end
                            3'd6: csum_d[15:8] = din_i;
                            3'd7: begin
                                csum_d[7:0] = din_i;
                                if (udp_len_q < WORD_W'(8)) begin
                                    err_d   = 1'b1;
                                    state_d = DROP;
                                end else if (dst_port_q != LOCAL_PORT) begin
                                    state_d = DROP;
                                end else if (udp_len_q == WORD_W'(8)) begin
                                    state_d = CHECK;
                                end else begin
                                    state_d = PAYLOAD;
                                end
                            end
                        endcase
                    end else if (valid_q) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
                PAYLOAD: begin
                    if (valid_i) begin
                        pl_data_d  = din_i;
                        pl_valid_d = 1'b1;
                        cnt_d      = cnt_inc_c;
                        if (!cnt_q[0]) hi_d = din_i;
                        else           sum_d = oc_add(sum_q, word_c);
                        if (cnt_q == udp_len_q - WORD_W'(1)) begin
                            pl_last_d = 1'b1;
                            state_d   = CHECK;
                            // Odd-length payload: final byte is padded with a zero low byte.
                            if (!cnt_q[0]) sum_d = oc_add(sum_q, {din_i, 8'h00});
                        end
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
                CHECK: begin
                    if (CSUM_EN && (csum_q != '0) && (sum_q != 16'hFFFF)) err_d  = 1'b1;
                    else                                                    done_d = 1'b1;
                    state_d = IDLE;
                end
                DROP: begin
                    if (!valid_i) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign src_port_o = src_port_q;
    assign dst_port_o = dst_port_q;
    assign udp_len_o  = udp_len_q;
    assign pl_data_o  = pl_data_q;
    assign pl_valid_o = pl_valid_q;
    assign pl_last_o  = pl_last_q;
    assign done_o     = done_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_udp_decode.sv
// Self-checking bench for udp_decode: directed scenarios plus randomized datagrams
// compared against a byte-stream reference model.
module tb_udp_decode;

    localparam logic [15:0] LOCAL_PORT = 16'd1234;
    localparam bit          CSUM_EN    = 1'b1;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [7:0]  din;
    logic        hdr_done;
    logic [31:0] ip_sa;
    logic [31:0] ip_da;
    logic [15:0] src_port_o;
    logic [15:0] dst_port_o;
    logic [15:0] udp_len_o;
    logic [7:0]  pl_data_o;
    logic        pl_valid_o;
    logic        pl_last_o;
    logic        done_o;
    logic        err_o;

    int n_cmp = 0;
    int n_bad = 0;

    logic [8:0] mon_q[$];
    bq_t        exp_pl;
    int         exp_last;
    bit         exp_done;
    bit         exp_err;

    always #5 clk = ~clk;

    udp_decode #(.LOCAL_PORT(LOCAL_PORT), .CSUM_EN(CSUM_EN)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (valid),
        .din_i      (din),
        .hdr_done_i (hdr_done),
        .ip_sa_i    (ip_sa),
        .ip_da_i    (ip_da),
        .src_port_o (src_port_o),
        .dst_port_o (dst_port_o),
        .udp_len_o  (udp_len_o),
        .pl_data_o  (pl_data_o),
        .pl_valid_o (pl_valid_o),
        .pl_last_o  (pl_last_o),
        .done_o     (done_o),
        .err_o      (err_o)
    );

    always @(negedge clk) if (pl_valid_o) mon_q.push_back({pl_last_o, pl_data_o});

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // UDP checksum over pseudo-header and the first len bytes, via a wide sum then folding.
    function automatic logic [15:0] csum_of(input logic [31:0] sa, input logic [31:0] da,
                                            input bq_t s, input int len);
        logic [31:0] acc;
        acc = 32'(sa[31:16]) + 32'(sa[15:0]) + 32'(da[31:16]) + 32'(da[15:0]) + 32'h11 + 32'(len);
        for (int i = 0; i < len; i += 2)
            acc += {16'h0, s[i], ((i + 1 < len) ? s[i+1] : 8'h00)};
        while (acc[31:16] != 16'h0) acc = 32'(acc[15:0]) + 32'(acc[31:16]);
        return acc[15:0];
    endfunction

    // mode: 0 = zero checksum field, 1 = correct, 2 = correct with bit 0 flipped
    function automatic bq_t make_dgram(input logic [31:0] sa, input logic [31:0] da,
                                       input logic [15:0] sp, input logic [15:0] dp,
                                       input logic [15:0] len, input int npay, input int mode);
        bq_t q;
        logic [15:0] c;
        q = {sp[15:8], sp[7:0], dp[15:8], dp[7:0], len[15:8], len[7:0], 8'h00, 8'h00};
        for (int i = 0; i < npay; i++) q.push_back(8'($urandom));
        if (mode != 0) begin
            c = ~csum_of(sa, da, q, int'(len));
            if (c == 16'h0000) c = 16'hFFFF;
            if (mode == 2) c = c ^ 16'h0001;
            q[6] = c[15:8];
            q[7] = c[7:0];
        end
        return q;
    endfunction

    // Expected behaviour for a stream of valid bytes following hdr_done.
    function automatic void model(input logic [31:0] sa, input logic [31:0] da, input bq_t s);
        int n;
        logic [15:0] len, dp, fld;
        n = s.size();
        exp_pl = {};
        exp_last = -1;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        if (n < 8) begin exp_err = 1'b1; return; end
        dp  = {s[2], s[3]};
        len = {s[4], s[5]};
        fld = {s[6], s[7]};
        if (len < 16'd8) begin exp_err = 1'b1; return; end
        if (dp != LOCAL_PORT) return;
        for (int i = 8; i < n && i < int'(len); i++) exp_pl.push_back(s[i]);
        if (n < int'(len)) begin exp_err = 1'b1; return; end
        if (len > 16'd8) exp_last = int'(len) - 9;
        if (CSUM_EN && fld != 16'h0 && csum_of(sa, da, s, int'(len)) != 16'hFFFF) exp_err = 1'b1;
        else exp_done = 1'b1;
    endfunction

    task automatic drive_frame(input logic [31:0] sa, input logic [31:0] da,
                               input bq_t s, input int tail);
        ip_sa = sa; ip_da = da; hdr_done = 1'b1; valid = 1'b1; din = 8'($urandom);
        tick;
        hdr_done = 1'b0;
        mon_q.delete();
        foreach (s[i]) begin din = s[i]; tick; end
        valid = 1'b0; din = 8'h00;
        repeat (tail) tick;
    endtask

    task automatic test_reset;
        rst = 1'b1; valid = 1'b1; hdr_done = 1'b0; din = 8'h5A;
        ip_sa = 32'h0; ip_da = 32'h0;
        tick; tick;
        n_cmp++;
        if ({src_port_o, dst_port_o, udp_len_o, pl_data_o, pl_valid_o, pl_last_o, done_o, err_o} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs got %h %h %h %h %b%b%b%b want all zero", src_port_o,
                     dst_port_o, udp_len_o, pl_data_o, pl_valid_o, pl_last_o, done_o, err_o);
        end
        rst = 1'b0; valid = 1'b0;
        tick;
    endtask

    task automatic test_basic;
        bq_t s;
        s = {8'h1F, 8'h90, 8'h04, 8'hD2, 8'h00, 8'h0A, 8'h00, 8'h00, 8'hAB, 8'hCD};
        drive_frame(32'hC0A80102, 32'hC0A80101, s, 3);
        n_cmp++;
        if ({src_port_o, dst_port_o, udp_len_o} !== {16'h1F90, 16'h04D2, 16'h000A}) begin
            n_bad++;
            $display("FAIL basic_hdr got %h %h %h want 1f90 04d2 000a", src_port_o, dst_port_o, udp_len_o);
        end
        n_cmp++;
        if (mon_q.size() != 2 || mon_q[0] !== 9'h0AB || mon_q[1] !== 9'h1CD) begin
            n_bad++;
            $display("FAIL basic_payload got %p want {0ab,1cd}", mon_q);
        end
        n_cmp++;
        if ({done_o, err_o} !== 2'b10) begin
            n_bad++;
            $display("FAIL basic_verdict got done=%b err=%b want done=1 err=0", done_o, err_o);
        end
    endtask

    task automatic test_checksum;
        bq_t s;
        for (int mode = 1; mode <= 2; mode++) begin
            s = {8'h1F, 8'h90, 8'h04, 8'hD2, 8'h00, 8'h0A, 8'h00, 8'h00, 8'hAB, 8'hCD};
            if (mode == 1) begin s[6] = 8'hAC; s[7] = 8'h56; end
            else begin s[6] = 8'hAC; s[7] = 8'h57; end
            drive_frame(32'hC0A80102, 32'hC0A80101, s, 3);
            n_cmp++;
            if ({done_o, err_o} !== ((mode == 1) ? 2'b10 : 2'b01)) begin
                n_bad++;
                $display("FAIL csum_mode%0d got done=%b err=%b", mode, done_o, err_o);
            end
            n_cmp++;
            if (mon_q.size() != 2) begin
                n_bad++;
                $display("FAIL csum_fwd_mode%0d got %0d bytes want 2", mode, mon_q.size());
            end
        end
    endtask

    task automatic test_drop;
        bq_t s;
        s = make_dgram(32'h0A000001, 32'h0A000002, 16'h2222, 16'h0050, 16'd10, 2, 0);
        drive_frame(32'h0A000001, 32'h0A000002, s, 3);
        n_cmp++;
        if ({mon_q.size() == 0, done_o, err_o, dst_port_o} !== {1'b1, 1'b0, 1'b0, 16'h0050}) begin
            n_bad++;
            $display("FAIL wrong_port got npl=%0d done=%b err=%b dst=%h want 0 0 0 0050",
                     mon_q.size(), done_o, err_o, dst_port_o);
        end
        s = make_dgram(32'h0A000001, 32'h0A000002, 16'h2222, LOCAL_PORT, 16'd5, 3, 0);
        drive_frame(32'h0A000001, 32'h0A000002, s, 3);
        n_cmp++;
        if ({mon_q.size() == 0, done_o, err_o} !== 3'b101) begin
            n_bad++;
            $display("FAIL len5 got npl=%0d done=%b err=%b want 0 0 1", mon_q.size(), done_o, err_o);
        end
        s = make_dgram(32'h0A000001, 32'h0A000002, 16'h2222, LOCAL_PORT, 16'd8, 0, 1);
        drive_frame(32'h0A000001, 32'h0A000002, s, 3);
        n_cmp++;
        if ({mon_q.size() == 0, done_o, err_o} !== 3'b110) begin
            n_bad++;
            $display("FAIL len8 got npl=%0d done=%b err=%b want 0 1 0", mon_q.size(), done_o, err_o);
        end
    endtask

    task automatic test_truncate;
        bq_t s;
        bit any_last;
        s = make_dgram(32'h01020304, 32'h05060708, 16'h3333, LOCAL_PORT, 16'h000C, 4, 1);
        void'(s.pop_back());
        void'(s.pop_back());
        drive_frame(32'h01020304, 32'h05060708, s, 3);
        any_last = 1'b0;
        foreach (mon_q[i]) any_last |= mon_q[i][8];
        n_cmp++;
        if ({mon_q.size() == 2, any_last, done_o, err_o} !== 4'b1001) begin
            n_bad++;
            $display("FAIL truncate got npl=%0d last=%b done=%b err=%b want 2 0 0 1",
                     mon_q.size(), any_last, done_o, err_o);
        end
    endtask

    task automatic test_rst_mid;
        bq_t s;
        s = make_dgram(32'hAC100001, 32'hAC100002, 16'h4444, LOCAL_PORT, 16'd12, 4, 0);
        ip_sa = 32'hAC100001; ip_da = 32'hAC100002;
        hdr_done = 1'b1; valid = 1'b1; tick; hdr_done = 1'b0;
        for (int i = 0; i < 10; i++) begin din = s[i]; tick; end
        rst = 1'b1; hdr_done = 1'b1; din = s[10];
        tick;
        n_cmp++;
        if ({src_port_o, dst_port_o, udp_len_o, pl_data_o, pl_valid_o, pl_last_o, done_o, err_o} !== '0) begin
            n_bad++;
            $display("FAIL rst_mid_outputs got %h %h %h %h %b%b%b%b want all zero", src_port_o,
                     dst_port_o, udp_len_o, pl_data_o, pl_valid_o, pl_last_o, done_o, err_o);
        end
        rst = 1'b0; hdr_done = 1'b0;
        mon_q.delete();
        for (int i = 0; i < 8; i++) begin din = s[i]; tick; end
        valid = 1'b0; tick; tick;
        n_cmp++;
        if ({mon_q.size() == 0, done_o, err_o} !== 3'b100) begin
            n_bad++;
            $display("FAIL rst_over_hdr_done got npl=%0d done=%b err=%b want 0 0 0",
                     mon_q.size(), done_o, err_o);
        end
        s = make_dgram(32'hAC100001, 32'hAC100002, 16'h4444, LOCAL_PORT, 16'd11, 3, 1);
        drive_frame(32'hAC100001, 32'hAC100002, s, 3);
        n_cmp++;
        if ({done_o, err_o, mon_q.size() == 3} !== 3'b101) begin
            n_bad++;
            $display("FAIL rst_recover got done=%b err=%b npl=%0d want 1 0 3", done_o, err_o, mon_q.size());
        end
    endtask

    task automatic test_abort;
        bq_t a, b;
        a = make_dgram(32'h11111111, 32'h22222222, 16'h5555, LOCAL_PORT, 16'd20, 12, 2);
        ip_sa = 32'h11111111; ip_da = 32'h22222222;
        hdr_done = 1'b1; valid = 1'b1; tick; hdr_done = 1'b0;
        for (int i = 0; i < 11; i++) begin din = a[i]; tick; end
        n_cmp++;
        if ({done_o, err_o} !== 2'b00) begin
            n_bad++;
            $display("FAIL abort_before got done=%b err=%b want 0 0", done_o, err_o);
        end
        b = make_dgram(32'h11111111, 32'h22222222, 16'hBEEF, LOCAL_PORT, 16'd10, 2, 1);
        drive_frame(32'h11111111, 32'h22222222, b, 3);
        n_cmp++;
        if ({done_o, err_o, src_port_o, mon_q.size() == 2} !== {2'b10, 16'hBEEF, 1'b1}) begin
            n_bad++;
            $display("FAIL abort_restart got done=%b err=%b src=%h npl=%0d want 1 0 beef 2",
                     done_o, err_o, src_port_o, mon_q.size());
        end
    endtask

    // tail = 1 puts the next hdr_done on the cycle right after the verdict.
    task automatic run_random(input string tag, input int nframes, input int tail);
        bq_t s;
        logic [31:0] sa, da;
        logic [15:0] sp, dp, len;
        int npay, cut;
        for (int f = 0; f < nframes; f++) begin
            sa = $urandom; da = $urandom; sp = 16'($urandom);
            dp = ($urandom_range(0, 99) < 85) ? LOCAL_PORT : 16'($urandom);
            len = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(0, 7)) : 16'($urandom_range(8, 40));
            npay = (len >= 16'd8) ? int'(len) - 8 : $urandom_range(0, 4);
            s = make_dgram(sa, da, sp, dp, len, npay, $urandom_range(0, 2));
            if ($urandom_range(0, 99) < 15) begin
                cut = $urandom_range(0, s.size() - 1);
                while (s.size() > cut) void'(s.pop_back());
            end else begin
                repeat ($urandom_range(0, 3)) s.push_back(8'($urandom));
            end
            drive_frame(sa, da, s, tail);
            model(sa, da, s);
            n_cmp++;
            if (mon_q.size() != exp_pl.size()) begin
                n_bad++;
                $display("FAIL %s%0d pl_count got %0d want %0d", tag, f, mon_q.size(), exp_pl.size());
            end else begin
                foreach (mon_q[i]) begin
                    n_cmp++;
                    if (mon_q[i] !== {(i == exp_last), exp_pl[i]}) begin
                        n_bad++;
                        $display("FAIL %s%0d pl[%0d] got %h want %h", tag, f, i, mon_q[i],
                                 {(i == exp_last), exp_pl[i]});
                    end
                end
            end
            n_cmp++;
            if ({done_o, err_o} !== {exp_done, exp_err}) begin
                n_bad++;
                $display("FAIL %s%0d verdict got done=%b err=%b want done=%b err=%b",
                         tag, f, done_o, err_o, exp_done, exp_err);
            end
            if (s.size() >= 8) begin
                n_cmp++;
                if ({src_port_o, dst_port_o, udp_len_o} !== {s[0], s[1], s[2], s[3], s[4], s[5]}) begin
                    n_bad++;
                    $display("FAIL %s%0d hdr got %h %h %h", tag, f, src_port_o, dst_port_o, udp_len_o);
                end
            end
        end
    endtask

    task automatic test_random;
        run_random("rnd", 40, 3);
    endtask

    task automatic test_back_to_back;
        run_random("b2b", 12, 1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_checksum();
        test_drop();
        test_truncate();
        test_rst_mid();
        test_abort();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
